// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder block.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } scan_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Generic combinational binary-to-one-hot decoder; all zeros when disabled.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  output logic [(2**SEL_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct select and auto-scan modes.
//
//   state     | meaning
//   ST_IDLE   | disabled, out low, idx held
//   ST_DIRECT | out/idx follow sel with one cycle latency
//   ST_SCAN   | idx walks 0..OUT_N-1, each held dwell+1 cycles
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  i_clk_sys,
  input  logic                  i_rst_b,
  input  logic                  i_enable,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [DWELL_W-1:0]    i_dwell,
  output logic [(2**SEL_W)-1:0] o_out,
  output logic [SEL_W-1:0]      o_idx,
  output logic                  o_wrap
);

  localparam int OUT_N = 2**SEL_W;

  scan_state_e          r_state;
  scan_state_e          w_state_nxt;
  logic [SEL_W-1:0]     r_idx;
  logic [SEL_W-1:0]     w_idx_nxt;
  logic [DWELL_W-1:0]   r_cnt;
  logic [DWELL_W-1:0]   w_cnt_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic                 w_out_en;
  logic [OUT_N-1:0]     r_out;
  logic [OUT_N-1:0]     w_onehot;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_b) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (i_enable) w_state_nxt = (i_mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
  end

  // Outputs are decided from the state being entered, so mode changes act on the very next edge.
  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = '0;
    w_wrap_nxt = 1'b0;
    w_out_en   = 1'b0;
    unique case (w_state_nxt)
      ST_DIRECT: begin
        w_idx_nxt = i_sel;
        w_out_en  = 1'b1;
      end
      ST_SCAN: begin
        w_out_en = 1'b1;
        if (r_state != ST_SCAN) begin
          w_idx_nxt = '0;
        end else if (r_cnt >= i_dwell) begin
          w_idx_nxt  = r_idx + 1'b1;
          w_wrap_nxt = (r_idx == SEL_W'(OUT_N - 1));
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_en     (w_out_en),
    .i_sel    (w_idx_nxt),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_b) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_out  <= '0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
      r_out  <= w_onehot;
    end
  end

  assign o_out  = r_out;
  assign o_idx  = r_idx;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Randomized and directed bench for scan_decoder at SEL_W = 1, 3 and 4 sharing one stimulus.
module tb_scan_decoder;

  logic       clk_sys = 1'b0;
  logic       rst_b;
  logic       enable;
  logic       mode;
  logic [3:0] sel;
  logic [7:0] dwell;

  logic [1:0]  out1;
  logic [0:0]  idx1;
  logic        wrap1;
  logic [7:0]  out3;
  logic [2:0]  idx3;
  logic        wrap3;
  logic [15:0] out4;
  logic [3:0]  idx4;
  logic        wrap4;

  always #5 clk_sys = ~clk_sys;

  scan_decoder #(.SEL_W(1), .DWELL_W(8)) u_dut1 (
    .i_clk_sys(clk_sys), .i_rst_b(rst_b), .i_enable(enable), .i_mode(mode),
    .i_sel(sel[0:0]), .i_dwell(dwell), .o_out(out1), .o_idx(idx1), .o_wrap(wrap1));

  scan_decoder #(.SEL_W(3), .DWELL_W(8)) u_dut3 (
    .i_clk_sys(clk_sys), .i_rst_b(rst_b), .i_enable(enable), .i_mode(mode),
    .i_sel(sel[2:0]), .i_dwell(dwell), .o_out(out3), .o_idx(idx3), .o_wrap(wrap3));

  scan_decoder #(.SEL_W(4), .DWELL_W(8)) u_dut4 (
    .i_clk_sys(clk_sys), .i_rst_b(rst_b), .i_enable(enable), .i_mode(mode),
    .i_sel(sel), .i_dwell(dwell), .o_out(out4), .o_idx(idx4), .o_wrap(wrap4));

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: per-width position in the scan plus how long the current index has been shown.
  int nn[3] = '{2, 8, 16};
  int m_idx[3];
  int m_held[3];
  bit m_wrap[3];
  bit m_on;
  bit m_in_scan;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit entering;
    entering = !m_in_scan;
    for (int k = 0; k < 3; k++) m_wrap[k] = 1'b0;
    if (!rst_b) begin
      for (int k = 0; k < 3; k++) begin m_idx[k] = 0; m_held[k] = 0; end
      m_on = 1'b0; m_in_scan = 1'b0;
    end else if (!enable) begin
      for (int k = 0; k < 3; k++) m_held[k] = 0;
      m_on = 1'b0; m_in_scan = 1'b0;
    end else if (!mode) begin
      for (int k = 0; k < 3; k++) begin m_idx[k] = int'(sel) % nn[k]; m_held[k] = 0; end
      m_on = 1'b1; m_in_scan = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (entering) begin
          m_idx[k] = 0; m_held[k] = 0;
        end else if (m_held[k] >= int'(dwell)) begin
          m_held[k] = 0;
          m_idx[k]  = (m_idx[k] + 1) % nn[k];
          m_wrap[k] = (m_idx[k] == 0);
        end else begin
          m_held[k]++;
        end
      end
      m_on = 1'b1; m_in_scan = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [63:0] o_out, o_idx;
    logic        o_wrap;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin o_out = 64'(out1); o_idx = 64'(idx1); o_wrap = wrap1; end
        1:       begin o_out = 64'(out3); o_idx = 64'(idx3); o_wrap = wrap3; end
        default: begin o_out = 64'(out4); o_idx = 64'(idx4); o_wrap = wrap4; end
      endcase
      chk($sformatf("out_w%0d", k), o_out, m_on ? (64'd1 << m_idx[k]) : 64'd0);
      chk($sformatf("idx_w%0d", k), o_idx, 64'(m_idx[k]));
      chk($sformatf("wrap_w%0d", k), 64'(o_wrap), 64'(m_wrap[k]));
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_edge();
    #1;
    compare_all();
  endtask

  int first_wrap[3];
  int cnt;

  initial begin
    m_in_scan = 1'b0; m_on = 1'b0;
    for (int k = 0; k < 3; k++) begin m_idx[k] = 0; m_held[k] = 0; m_wrap[k] = 1'b0; end

    rst_b = 1'b0; enable = 1'b1; mode = 1'b1; sel = 4'd9; dwell = 8'd3;
    step(); step();
    chk("rst_out", 64'(out3), 64'd0);
    chk("rst_idx", 64'(idx3), 64'd0);

    rst_b = 1'b1; mode = 1'b0; sel = 4'd5;
    step();
    chk("dir5_out", 64'(out3), 64'h20);
    chk("dir5_idx", 64'(idx3), 64'd5);
    enable = 1'b0;
    step();
    chk("gate_out", 64'(out3), 64'd0);
    chk("gate_idx", 64'(idx3), 64'd5);

    enable = 1'b1;
    for (int s = 0; s < 16; s++) begin sel = 4'(s); step(); end

    // dwell=2: first wrap one full period after entry for each width
    mode = 1'b1; dwell = 8'd2;
    step();
    for (int k = 0; k < 3; k++) first_wrap[k] = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (wrap1 && first_wrap[0] < 0) first_wrap[0] = c;
      if (wrap3 && first_wrap[1] < 0) first_wrap[1] = c;
      if (wrap4 && first_wrap[2] < 0) first_wrap[2] = c;
    end
    chk("wrap_period_w1", 64'(first_wrap[0]), 64'd6);
    chk("wrap_period_w3", 64'(first_wrap[1]), 64'd24);
    chk("wrap_period_w4", 64'(first_wrap[2]), 64'd48);

    // dwell=0: advance every cycle
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd0;
    step();
    cnt = 0;
    for (int c = 0; c < 20; c++) begin step(); if (wrap1) cnt++; end
    chk("dwell0_w1_wraps", 64'(cnt), 64'd10);

    // Lower dwell below the running count mid-hold
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd10;
    step();
    for (int c = 0; c < 5; c++) step();
    chk("hold_idx", 64'(idx3), 64'd0);
    dwell = 8'd1;
    step();
    chk("cut_adv", 64'(idx3), 64'd1);
    step(); step();
    chk("cut_hold2", 64'(idx3), 64'd2);

    // SCAN -> DIRECT -> SCAN
    mode = 1'b0; step();
    mode = 1'b1; dwell = 8'd0;
    step();
    for (int c = 0; c < 4; c++) step();
    chk("scan_at4", 64'(idx3), 64'd4);
    mode = 1'b0; sel = 4'd2;
    step();
    chk("sw_direct", 64'(out3), 64'h04);
    mode = 1'b1;
    step();
    chk("reenter_idx", 64'(idx3), 64'd0);

    // Reset mid-scan, then immediate re-entry
    dwell = 8'd1;
    for (int c = 0; c < 7; c++) step();
    rst_b = 1'b0;
    step();
    chk("midrst_out", 64'(out4), 64'd0);
    chk("midrst_wrap", 64'(wrap3), 64'd0);
    rst_b = 1'b1;
    step();
    chk("post_rst_out", 64'(out3), 64'h01);

    for (int c = 0; c < 1500; c++) begin
      rst_b  = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 9) != 0);
      mode   = ($urandom_range(0, 3) != 0);
      sel    = 4'($urandom);
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 4));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
